// File: rtl/fetch_icache_direct.sv
// Direct-mapped instruction cache for the IF stage with single-line refill FSM.
// Optional ICACHE_FLUSH_EN adds a flush port that invalidates all lines.
module fetch_icache_direct #(
  parameter int ADDR_W         = 32,
  parameter int LINES          = 8,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  input  logic [ADDR_W-1:0]           address,
  output logic [31:0]                 instruction,
  output logic                        hit,
  output logic                        stall,
  output logic                        mem_req,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic                        mem_valid,
  input  logic [32*WORDS_PER_LINE-1:0] mem_in
`ifdef ICACHE_FLUSH_EN
  ,
  input  logic                        flush
`endif
);

  localparam int OFF   = $clog2(WORDS_PER_LINE);
  localparam int IDX   = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX - OFF - 2;
  localparam int LW    = 32 * WORDS_PER_LINE;

  typedef enum logic [1:0] {
    IDLE,
    MISS,
    FILL
  } state_t;

  state_t           state;
  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [LW-1:0]    data_q [LINES];
  logic [IDX-1:0]   miss_idx;
  logic [TAG_W-1:0] miss_tag;
  logic             flush_pend;
  logic             flush_w;

  logic [OFF-1:0]   word;
  logic [IDX-1:0]   idx;
  logic [TAG_W-1:0] tag;
  logic             lookup;

`ifdef ICACHE_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign word   = address[OFF+1:2];
  assign idx    = address[IDX+OFF+1:OFF+2];
  assign tag    = address[ADDR_W-1:IDX+OFF+2];
  assign lookup = valid_q[idx] && (tag_q[idx] == tag);

  assign hit = req_valid && (state == IDLE)
            && lookup && !flush_w;

  assign instruction = hit ? data_q[idx][{word, 5'b0} +: 32]
                           : 32'h0;

  // Gated by reset so the PC is never held while the cache is in reset
  assign stall = rst && ((state != IDLE)
              || (req_valid && !hit));

  assign mem_addr = {miss_tag, miss_idx, {(OFF+2){1'b0}}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      valid_q    <= '0;
      miss_idx   <= '0;
      miss_tag   <= '0;
      mem_req    <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (flush_w) valid_q <= '0;
          if (req_valid && !hit) begin
            state    <= MISS;
            miss_idx <= idx;
            miss_tag <= tag;
            mem_req  <= 1'b1;
          end
        end
        MISS: begin
          if (flush_w) flush_pend <= 1'b1;
          if (mem_valid) begin
            valid_q[miss_idx] <= 1'b1;
            mem_req           <= 1'b0;
            state             <= FILL;
          end
        end
        FILL: begin
          // Deferred flush also drops the line just filled
          if (flush_w || flush_pend) valid_q <= '0;
          flush_pend <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == MISS && mem_valid) begin
      data_q[miss_idx] <= mem_in;
      tag_q[miss_idx]  <= miss_tag;
    end
  end

endmodule

// File: tb/tb_fetch_icache_direct.sv
// Randomized self-checking bench for fetch_icache_direct (8 lines x 4 words).
// Reference model is a plain array of valid/tag/line kept per index.
module tb_fetch_icache_direct;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic [31:0]  address;
  logic [31:0]  instruction;
  logic         hit;
  logic         stall;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_valid;
  logic [127:0] mem_in;
`ifdef ICACHE_FLUSH_EN
  logic         flush;
`endif

  int checks   = 0;
  int failures = 0;

  bit           m_valid [8];
  logic [24:0]  m_tag   [8];
  logic [127:0] m_data  [8];

  fetch_icache_direct #(
    .ADDR_W(32),
    .LINES(8),
    .WORDS_PER_LINE(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .address(address),
    .instruction(instruction),
    .hit(hit),
    .stall(stall),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_valid(mem_valid),
    .mem_in(mem_in)
`ifdef ICACHE_FLUSH_EN
    ,
    .flush(flush)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0]  a,
                          input logic [127:0] line,
                          input int           lat,
                          input bit           fl);
    logic [2:0]  ix;
    logic [24:0] tg;
    int          w;
    bit          exp_hit;
    ix = a[6:4];
    tg = a[31:7];
    w  = int'(a[3:2]);
    exp_hit = m_valid[ix] && (m_tag[ix] == tg);
    req_valid = 1'b1;
    address   = a;
    mem_valid = 1'($urandom_range(0, 1));
    mem_in    = rnd_line();
    @(negedge clk);
    chk("hit", 32'(hit), 32'(exp_hit));
    chk("stall", 32'(stall), 32'(!exp_hit));
    chk("instr", instruction,
        exp_hit ? m_data[ix][w*32 +: 32] : 32'h0);
    step();
    mem_valid = 1'b0;
    if (!exp_hit) begin
`ifdef ICACHE_FLUSH_EN
      flush = fl;
`endif
      for (int i = 0; i < lat; i++) begin
        req_valid = 1'($urandom_range(0, 1));
        address   = $urandom;
        @(negedge clk);
        chk("miss_req", 32'(mem_req), 32'd1);
        chk("miss_addr", mem_addr, {a[31:4], 4'h0});
        chk("miss_stall", 32'(stall), 32'd1);
        chk("miss_hit", 32'(hit), 32'd0);
        step();
`ifdef ICACHE_FLUSH_EN
        flush = 1'b0;
`endif
      end
      mem_valid = 1'b1;
      mem_in    = line;
      @(negedge clk);
      chk("resp_req", 32'(mem_req), 32'd1);
      chk("resp_addr", mem_addr, {a[31:4], 4'h0});
      chk("resp_stall", 32'(stall), 32'd1);
      step();
`ifdef ICACHE_FLUSH_EN
      flush = 1'b0;
`endif
      mem_valid = 1'($urandom_range(0, 1));
      mem_in    = rnd_line();
      req_valid = 1'($urandom_range(0, 1));
      address   = a;
      @(negedge clk);
      chk("fill_req", 32'(mem_req), 32'd0);
      chk("fill_stall", 32'(stall), 32'd1);
      chk("fill_hit", 32'(hit), 32'd0);
      step();
      mem_valid  = 1'b0;
      m_valid[ix] = 1'b1;
      m_tag[ix]   = tg;
      m_data[ix]  = line;
`ifdef ICACHE_FLUSH_EN
      if (fl) clear_model();
`endif
    end
    req_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    rst       = 1'b0;
    req_valid = 1'b1;
    address   = 32'h8;
    mem_valid = 1'b0;
    mem_in    = '0;
`ifdef ICACHE_FLUSH_EN
    flush     = 1'b0;
`endif
    clear_model();
    @(negedge clk);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_mreq", 32'(mem_req), 32'd0);
    chk("rst_maddr", mem_addr, 32'h0);
    step();
    rst = 1'b1;

    do_fetch(32'h8, 128'hFFFFFFFF_00000000_FFFFFFFF_00007C00, 0, 1'b0);
    do_fetch(32'h8, '0, 0, 1'b0);
    do_fetch(32'h4, '0, 0, 1'b0);
    do_fetch(32'h0, '0, 0, 1'b0);

    do_fetch(32'h80, rnd_line(), 2, 1'b0);
    do_fetch(32'h8, rnd_line(), 1, 1'b0);
    do_fetch(32'h20, rnd_line(), 5, 1'b0);
    do_fetch(32'h24, '0, 0, 1'b0);

    req_valid = 1'b1;
    address   = 32'h0000_1008;
    step();
    @(negedge clk);
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("midrst_req", 32'(mem_req), 32'd0);
    chk("midrst_stall", 32'(stall), 32'd0);
    chk("midrst_hit", 32'(hit), 32'd0);
    clear_model();
    step();
    rst = 1'b1;
    req_valid = 1'b0;
    do_fetch(32'h8, rnd_line(), 3, 1'b0);

`ifdef ICACHE_FLUSH_EN
    flush = 1'b1;
    step();
    flush = 1'b0;
    clear_model();
    do_fetch(32'h4, rnd_line(), 1, 1'b0);
    do_fetch(32'h104, rnd_line(), 2, 1'b1);
    do_fetch(32'h104, rnd_line(), 1, 1'b0);
`endif

    for (int n = 0; n < 200; n++) begin
      a = (32'($urandom_range(0, 3)) << 7)
        | (32'($urandom_range(0, 31)) << 2);
      if ($urandom_range(0, 15) == 0) a = {$urandom, 2'b00} & 32'hFFFF_FFFC;
`ifdef ICACHE_FLUSH_EN
      if ($urandom_range(0, 19) == 0) begin
        flush = 1'b1;
        step();
        flush = 1'b0;
        clear_model();
      end
`endif
      do_fetch(a, rnd_line(), $urandom_range(0, 5),
               1'($urandom_range(0, 7) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
